// File: rtl/trig_counter_pkg.sv
// rtl/trig_counter_pkg.sv - trigger indices, state encoding and status layout for trig_counter
package trig_counter_pkg;

  // Bit positions within the trig input
  localparam int TRIG_CLEAR     = 0;
  localparam int TRIG_STEP_UP   = 1;
  localparam int TRIG_STEP_DOWN = 2;
  localparam int TRIG_LOAD      = 3;
  localparam int TRIG_RUN_UP    = 4;
  localparam int TRIG_RUN_DOWN  = 5;
  localparam int TRIG_STOP      = 6;
  localparam int TRIG_SNAPSHOT  = 7;

  // Encoding 2'd3 is never produced and is read back as ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_UP   = 2'd1,
    ST_RUN_DOWN = 2'd2
  } state_e;

  // Bit positions within the status output
  localparam int STAT_STATE_LSB  = 0;
  localparam int STAT_OVERFLOW   = 2;
  localparam int STAT_SNAP_VALID = 3;

endpackage

// File: rtl/trig_counter_prescale.sv
// rtl/trig_counter_prescale.sv - down-counting run-rate prescaler, one tick every prescale+1 enabled cycles
module trig_counter_prescale #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk1,
  input  logic                  reset,
  input  logic                  reload,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] cnt_q;

  // Tick on the enabled cycle in which the countdown has reached zero
  assign tick = enable && (cnt_q == '0);

  // Countdown; reload (explicit or at tick) samples the current prescale so changes apply then
  always_ff @(posedge clk1) begin
    if (reset || reload) begin
      cnt_q <= prescale;
    end else if (enable) begin
      if (tick) begin
        cnt_q <= prescale;
      end else begin
        cnt_q <= cnt_q - ONE;
      end
    end
  end

endmodule

// File: rtl/trig_counter.sv
// rtl/trig_counter.sv - 32-bit trigger-driven up/down counter with snapshot; TRIG_COUNTER_SAT_EN selects saturation
module trig_counter
  import trig_counter_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk1,
  input  logic                  reset,
  input  logic [7:0]            trig,
  input  logic [15:0]           load_lo,
  input  logic [15:0]           load_hi,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [31:0]           count,
  output logic [15:0]           snap_lo,
  output logic [15:0]           snap_hi,
  output logic [15:0]           status,
  output logic                  tc_pulse
);

  state_e      state_q, state_d, cur_state;
  logic [31:0] count_q, count_d;
  logic [31:0] snap_q;
  logic        snap_valid_q;
  logic        ovf_q, ovf_d;
  logic        tc_q, tc_d;
  logic        tick;
  logic        reload;
  logic        do_up, do_dn;

  assign reload = trig[TRIG_CLEAR] | trig[TRIG_LOAD] | trig[TRIG_RUN_UP] | trig[TRIG_RUN_DOWN];

  trig_counter_prescale #(.PRESCALE_W(PRESCALE_W)) u_prescale (
    .clk1     (clk1),
    .reset    (reset),
    .reload   (reload),
    .enable   (cur_state != ST_IDLE),
    .prescale (prescale),
    .tick     (tick)
  );

  // Fold the unreachable encoding back onto IDLE
  always_comb begin
    cur_state = ST_IDLE;
    case (state_q)
      ST_RUN_UP:   cur_state = ST_RUN_UP;
      ST_RUN_DOWN: cur_state = ST_RUN_DOWN;
      default:     cur_state = ST_IDLE;
    endcase
  end

  // Prioritised trigger decode, then one-step arithmetic with wrap or saturation
  always_comb begin
    count_d = count_q;
    state_d = cur_state;
    ovf_d   = ovf_q;
    tc_d    = 1'b0;
    do_up   = 1'b0;
    do_dn   = 1'b0;
    if (trig[TRIG_CLEAR]) begin
      count_d = '0;
      ovf_d   = 1'b0;
      state_d = ST_IDLE;
    end else if (trig[TRIG_LOAD]) begin
      count_d = {load_hi, load_lo};
    end else if (trig[TRIG_STOP]) begin
      state_d = ST_IDLE;
    end else if (trig[TRIG_RUN_UP]) begin
      state_d = ST_RUN_UP;
    end else if (trig[TRIG_RUN_DOWN]) begin
      state_d = ST_RUN_DOWN;
    end else if (cur_state == ST_IDLE) begin
      do_up = trig[TRIG_STEP_UP] & ~trig[TRIG_STEP_DOWN];
      do_dn = trig[TRIG_STEP_DOWN] & ~trig[TRIG_STEP_UP];
    end else if (tick) begin
      do_up = (cur_state == ST_RUN_UP);
      do_dn = (cur_state == ST_RUN_DOWN);
    end

    if (do_up) begin
      if (count_q == 32'hFFFF_FFFF) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
`ifdef TRIG_COUNTER_SAT_EN
        state_d = ST_IDLE;
`else
        count_d = 32'd0;
`endif
      end else begin
        count_d = count_q + 32'd1;
      end
    end else if (do_dn) begin
      if (count_q == 32'd0) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
`ifdef TRIG_COUNTER_SAT_EN
        state_d = ST_IDLE;
`else
        count_d = 32'hFFFF_FFFF;
`endif
      end else begin
        count_d = count_q - 32'd1;
      end
    end
  end

  // Counter, state, sticky and terminal-count registers
  always_ff @(posedge clk1) begin
    if (reset) begin
      count_q <= '0;
      state_q <= ST_IDLE;
      ovf_q   <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
      tc_q    <= tc_d;
    end
  end

  // Snapshot takes the registered count, ignoring any same-cycle update
  always_ff @(posedge clk1) begin
    if (reset) begin
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
    end else if (trig[TRIG_SNAPSHOT]) begin
      snap_q       <= count_q;
      snap_valid_q <= 1'b1;
    end
  end

  assign count    = count_q;
  assign snap_lo  = snap_q[15:0];
  assign snap_hi  = snap_q[31:16];
  assign tc_pulse = tc_q;

  always_comb begin
    status = '0;
    status[STAT_STATE_LSB +: 2] = cur_state;
    status[STAT_OVERFLOW]       = ovf_q;
    status[STAT_SNAP_VALID]     = snap_valid_q;
  end

endmodule

// File: tb/tb_trig_counter.sv
// tb/tb_trig_counter.sv - self-checking bench for trig_counter: vector table, corner sequences, randomized model comparison
module tb_trig_counter;

  logic        clk1 = 1'b0;
  logic        reset;
  logic [7:0]  trig;
  logic [15:0] load_lo, load_hi;
  logic [15:0] prescale;
  logic [31:0] count;
  logic [15:0] snap_lo, snap_hi, status;
  logic        tc_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  trig_counter #(.PRESCALE_W(16)) dut (
    .clk1     (clk1),
    .reset    (reset),
    .trig     (trig),
    .load_lo  (load_lo),
    .load_hi  (load_hi),
    .prescale (prescale),
    .count    (count),
    .snap_lo  (snap_lo),
    .snap_hi  (snap_hi),
    .status   (status),
    .tc_pulse (tc_pulse)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic [7:0]  t;
    logic [31:0] ld;
    logic [31:0] exp_count;
    logic        exp_tc;
    logic [15:0] exp_status;
  } vec_t;

  vec_t vecs[14];

  // behavioural reference state
  logic [31:0] m_count, m_snap;
  logic        m_sv, m_ovf, m_tc;
  int          m_state;
  int          m_phase, m_period;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // drive one cycle of inputs, let the edge happen, sample 1 time unit later
  task automatic apply(input logic [7:0] t, input logic [31:0] ld);
    trig    = t;
    load_hi = ld[31:16];
    load_lo = ld[15:0];
    @(posedge clk1);
    #1;
    trig = 8'h00;
  endtask

  // step the model by one clock with the given inputs
  task automatic model_cycle(input logic rst, input logic [7:0] t, input logic [31:0] ld);
    logic [31:0] prev;
    logic        running, tick_now;
    int          dir;
    longint      nv;
    prev = m_count;
    m_tc = 1'b0;
    if (rst) begin
      m_count = 0; m_snap = 0; m_sv = 0; m_ovf = 0; m_state = 0;
      m_phase = 0; m_period = int'(prescale);
      return;
    end
    if (t[7]) begin m_snap = prev; m_sv = 1'b1; end
    running  = (m_state != 0);
    tick_now = running && (m_phase == m_period);
    if (t[0] | t[3] | t[4] | t[5]) begin
      m_phase = 0; m_period = int'(prescale);
    end else if (running) begin
      if (tick_now) begin m_phase = 0; m_period = int'(prescale); end
      else m_phase++;
    end
    dir = 0;
    if (t[0]) begin m_count = 0; m_ovf = 0; m_state = 0; end
    else if (t[3]) m_count = ld;
    else if (t[6]) m_state = 0;
    else if (t[4]) m_state = 1;
    else if (t[5]) m_state = 2;
    else if (m_state == 0) dir = int'(t[1]) - int'(t[2]);
    else if (tick_now) dir = (m_state == 1) ? 1 : -1;
    if (dir != 0) begin
      nv = longint'(m_count) + longint'(dir);
      if (nv < 0 || nv > 64'h0000_0000_FFFF_FFFF) begin
        m_tc = 1'b1; m_ovf = 1'b1;
`ifdef TRIG_COUNTER_SAT_EN
        m_state = 0;
`else
        m_count = (nv < 0) ? 32'hFFFF_FFFF : 32'd0;
`endif
      end else begin
        m_count = nv[31:0];
      end
    end
  endtask

  function automatic logic [7:0] rand_trig();
    logic [7:0] t;
    t = 8'h00;
    for (int b = 1; b < 8; b++)
      if ($urandom_range(0, 11) == 0) t[b] = 1'b1;
    if ($urandom_range(0, 59) == 0) t[0] = 1'b1;
    return t;
  endfunction

  function automatic logic [31:0] rand_load();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'hFFFF_FFFE;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; trig = 8'h00; load_lo = 16'h0; load_hi = 16'h0; prescale = 16'd0;
    repeat (2) @(posedge clk1);
    #1;
    reset = 1'b0;
    chk("reset_count", count, 32'd0);
    chk("reset_status", {16'd0, status}, 32'd0);
    chk("reset_snap", {snap_hi, snap_lo}, 32'd0);
    chk("reset_tc", {31'd0, tc_pulse}, 32'd0);

    vecs[0]  = '{8'h02, 32'd0, 32'd1, 1'b0, 16'h0000};
    vecs[1]  = '{8'h02, 32'd0, 32'd2, 1'b0, 16'h0000};
    vecs[2]  = '{8'h02, 32'd0, 32'd3, 1'b0, 16'h0000};
    vecs[3]  = '{8'h06, 32'd0, 32'd3, 1'b0, 16'h0000};
    vecs[4]  = '{8'h08, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 16'h0000};
    vecs[5]  = '{8'h02, 32'd0, 32'hFFFF_FFFF, 1'b0, 16'h0000};
`ifdef TRIG_COUNTER_SAT_EN
    vecs[6]  = '{8'h02, 32'd0, 32'hFFFF_FFFF, 1'b1, 16'h0004};
    vecs[7]  = '{8'h00, 32'd0, 32'hFFFF_FFFF, 1'b0, 16'h0004};
`else
    vecs[6]  = '{8'h02, 32'd0, 32'd0, 1'b1, 16'h0004};
    vecs[7]  = '{8'h00, 32'd0, 32'd0, 1'b0, 16'h0004};
`endif
    vecs[8]  = '{8'h08, 32'd7, 32'd7, 1'b0, 16'h0004};
    vecs[9]  = '{8'h06, 32'd0, 32'd7, 1'b0, 16'h0004};
    vecs[10] = '{8'h09, 32'h0000_1234, 32'd0, 1'b0, 16'h0000};
`ifdef TRIG_COUNTER_SAT_EN
    vecs[11] = '{8'h04, 32'd0, 32'd0, 1'b1, 16'h0004};
`else
    vecs[11] = '{8'h04, 32'd0, 32'hFFFF_FFFF, 1'b1, 16'h0004};
`endif
    vecs[12] = '{8'h01, 32'd0, 32'd0, 1'b0, 16'h0000};
    vecs[13] = '{8'h80, 32'd0, 32'd0, 1'b0, 16'h0008};

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].t, vecs[i].ld);
      chk($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
      chk($sformatf("vec%0d_tc", i), {31'd0, tc_pulse}, {31'd0, vecs[i].exp_tc});
      chk($sformatf("vec%0d_status", i), {16'd0, status}, {16'd0, vecs[i].exp_status});
    end

    // run up at prescale 3 for 20 cycles, then stop
    prescale = 16'd3;
    apply(8'h01, 32'd0);
    apply(8'h10, 32'd0);
    chk("run_state", {30'd0, status[1:0]}, 32'd1);
    repeat (20) apply(8'h00, 32'd0);
    apply(8'h40, 32'd0);
    chk("run_count", count, 32'd5);
    chk("run_stopped", {30'd0, status[1:0]}, 32'd0);

    // snapshot coincident with a run step across a 16-bit boundary
    prescale = 16'd0;
    apply(8'h08, 32'h0001_FFFE);
    apply(8'h10, 32'd0);
    chk("pre_snap_count0", count, 32'h0001_FFFE);
    apply(8'h00, 32'd0);
    chk("pre_snap_count1", count, 32'h0001_FFFF);
    apply(8'h80, 32'd0);
    chk("snap_hi", {16'd0, snap_hi}, 32'h0000_0001);
    chk("snap_lo", {16'd0, snap_lo}, 32'h0000_FFFF);
    chk("snap_count", count, 32'h0002_0000);
    apply(8'h40, 32'd0);
    chk("snap_hold", {snap_hi, snap_lo}, 32'h0001_FFFF);

    // reset during RUN_DOWN at count 0, with triggers present
    apply(8'h08, 32'd0);
    apply(8'h20, 32'd0);
    chk("rd_state", {30'd0, status[1:0]}, 32'd2);
    reset = 1'b1;
    apply(8'h06, 32'd0);
    reset = 1'b0;
    chk("rst_run_count", count, 32'd0);
    chk("rst_run_status", {16'd0, status}, 32'd0);
    chk("rst_run_tc", {31'd0, tc_pulse}, 32'd0);
    apply(8'h00, 32'd0);
    chk("rst_run_tc_after", {31'd0, tc_pulse}, 32'd0);
    chk("rst_run_count_after", count, 32'd0);

    // randomized run against the reference model
    reset = 1'b1;
    model_cycle(1'b1, 8'h00, 32'd0);
    apply(8'h00, 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic [7:0]  t;
      logic [31:0] ld;
      logic        r;
      if (c % 64 == 0) prescale = 16'($urandom_range(0, 3));
      t  = rand_trig();
      ld = rand_load();
      r  = ($urandom_range(0, 299) == 0);
      reset = r;
      model_cycle(r, t, ld);
      apply(t, ld);
      reset = 1'b0;
      chk("rnd_count", count, m_count);
      chk("rnd_tc", {31'd0, tc_pulse}, {31'd0, m_tc});
      chk("rnd_status", {16'd0, status}, {16'd0, 12'd0, m_sv, m_ovf, 2'(m_state)});
      chk("rnd_snap", {snap_hi, snap_lo}, m_snap);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trig_counter.md
TRIG_COUNTER -- requirements
Module: trig_counter

Interface
REQ-001 Parameter PRESCALE_W, default 16, sets the width of the prescale input and of the internal prescaler.
REQ-002 clk1  in  1  sole clock; all logic SHALL be synchronous to it.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 trig  in  8  one-cycle trigger pulses in the clk1 domain: [0] clear, [1] step up, [2] step down, [3] load, [4] run up, [5] run down, [6] stop, [7] snapshot.
REQ-005 load_lo, load_hi  in  16 each  host-written value, applied as count = {load_hi, load_lo}.
REQ-006 prescale  in  PRESCALE_W  run rate; one run step every prescale+1 cycles.
REQ-007 count  out  32  live counter value.
REQ-008 snap_lo, snap_hi  out  16 each  coherent snapshot of count for two-word host readout.
REQ-009 status  out  16  [1:0] state, [2] overflow sticky, [3] snapshot valid, [15:4] zero.
REQ-010 tc_pulse  out  1  one-cycle terminal-count event, intended for a trigger-out endpoint.

Function
REQ-011 States: IDLE=0, RUN_UP=1, RUN_DOWN=2; encoding 3 SHALL be unreachable and SHALL decode to IDLE.
REQ-012 Per-cycle priority: clear > load > stop > run up > run down > step up/down.
REQ-013 Clear SHALL zero count, clear overflow sticky, reload the prescaler, and force IDLE.
REQ-014 Load SHALL set count, reload the prescaler, and leave the state unchanged.
REQ-015 Stop SHALL force IDLE; run up/run down SHALL enter RUN_UP/RUN_DOWN from any state and reload the prescaler.
REQ-016 Manual steps SHALL apply only in IDLE.
REQ-017 Manual step up and step down in the same cycle SHALL cancel, leaving count unchanged.
REQ-018 In RUN states the prescaler SHALL count down from prescale to 0, step count by one at 0, and reload.
REQ-019 prescale = 0 SHALL yield one step per cycle.
REQ-020 A changed prescale value SHALL take effect at the next reload.
REQ-021 All count changes SHALL be visible on count one cycle after the causing trigger or tick.
REQ-022 Snapshot SHALL capture count as registered in the trigger cycle, before any same-cycle update.
REQ-023 snap_lo/snap_hi SHALL change only on snapshot, and status[3] SHALL set one cycle after the trigger.
REQ-024 Arithmetic is modulo 2^32 unless REQ-031 applies.
REQ-025 A wrap in either direction (0xFFFFFFFF->0 or 0->0xFFFFFFFF) SHALL assert tc_pulse for exactly one cycle, coincident with the new count, and set overflow sticky.
REQ-026 Load/clear SHALL never generate tc_pulse.

Reset
REQ-027 On reset: count=0, snap_lo=snap_hi=0, status=0, tc_pulse=0, state IDLE, prescaler loaded with prescale.
REQ-028 Reset SHALL override all triggers in the same cycle.
REQ-029 Reset mid-run SHALL return to IDLE with no tc_pulse.

Configuration
REQ-030 Macro TRIG_COUNTER_SAT_EN selects saturating arithmetic.
REQ-031 With TRIG_COUNTER_SAT_EN defined, count SHALL hold at 0xFFFFFFFF or 0; each suppressed step SHALL assert tc_pulse for one cycle and set overflow sticky; a run that saturates SHALL return to IDLE.
REQ-032 Without TRIG_COUNTER_SAT_EN, wrap behaviour per REQ-024/REQ-025 applies and runs continue.

Structure
REQ-033 Package trig_counter_pkg SHALL hold trigger bit indices, the state enum, and status bit positions.
REQ-034 The prescaler SHALL be a sub-module trig_counter_prescale (inputs clk1, reset, reload, enable, prescale; output tick).

Verification
REQ-035 Reset, then step up x3 -> count=3 one cycle after each step; tc_pulse never asserted.
REQ-036 Load 0xFFFF/0xFFFE, step up x2 -> count 0xFFFFFFFF then 0x00000000 with tc_pulse=1 on the second update, status[2]=1; the same test with SAT_EN gives count held at 0xFFFFFFFF, tc_pulse on the second step.
REQ-037 prescale=3, run up for 20 cycles, stop -> count=5, status[1:0]=0 after the stop.
REQ-038 Step up and step down in the same cycle at count=7 -> count stays 7; clear and load in the same cycle -> count=0.
REQ-039 count=0x0001FFFF, snapshot coincident with a run step -> snap_hi=0x0001, snap_lo=0xFFFF, count=0x00020000.
REQ-040 Reset asserted during RUN_DOWN at count=0 -> count=0, IDLE, no tc_pulse.
